// File: rtl/fg_sequencer_pkg.sv
// Shared types for the function generator and its segment sequencer.
package PKG_FunctionGenerator;

    localparam int bitsDelta = 8;

    typedef enum logic [1:0] {
        SAWTOOTH = 2'd0,
        TRIANGLE = 2'd1,
        SQUARE   = 2'd2,
        SINE     = 2'd3
    } type_t;

    // Duration field width stored in each segment entry.
    localparam int DUR_BITS_DEFAULT = 16;

    typedef struct packed {
        type_t                        shape;
        logic [bitsDelta-1:0]         delta;
        logic [DUR_BITS_DEFAULT-1:0]  dur;
    } seg_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/fg_seq_mem.sv
// Segment list storage: synchronous write, asynchronous read, no reset.
module fg_seq_mem
    import PKG_FunctionGenerator::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  seg_t          wdata,
    input  logic [AW-1:0] raddr,
    output seg_t          rdata
);

    seg_t mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fg_sequencer.sv
// Replays a programmed list of (shape, delta, duration) segments into the
// function generator's sel/delta inputs, once or in a loop.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | not playing; host may write entries; waits for start
//   LOAD  | one cycle per visited entry; latch entry or skip if dur==0
//   RUN   | segment active; prescaler + tick counter measure duration
module fg_sequencer
    import PKG_FunctionGenerator::*;
#(
    parameter int DEPTH    = 16,
    parameter int DUR_BITS = DUR_BITS_DEFAULT,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  type_t                wr_shape,
    input  logic [bitsDelta-1:0] wr_delta,
    input  logic [DUR_BITS-1:0]  wr_dur,
    output logic                 wr_rej,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 loop,
    input  logic [AW-1:0]        last_idx,
    output type_t                sel,
    output logic [bitsDelta-1:0] delta,
    output logic                 gen_en,
    output logic                 busy,
    output logic [AW-1:0]        seg_idx,
    output logic                 done
);

    seq_state_t           state, state_nxt;
    logic [AW-1:0]        idx_nxt, last_r, last_nxt, adv_idx;
    logic                 loop_r, loop_nxt, adv_last;
    type_t                sel_nxt;
    logic [bitsDelta-1:0] delta_nxt, cnt, cnt_nxt;
    logic [DUR_BITS-1:0]  ticks, ticks_nxt;
    logic                 gen_nxt, done_nxt, rej_nxt, mem_we;
    seg_t                 wr_seg, rd_seg;

    assign wr_seg = '{shape: wr_shape, delta: wr_delta, dur: wr_dur};

    fg_seq_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_addr),
        .wdata (wr_seg),
        .raddr (seg_idx),
        .rdata (rd_seg)
    );

    assign busy = (state != IDLE);

    // Where the list goes after the current entry finishes or is skipped.
    always_comb begin
        adv_idx  = '0;
        adv_last = 1'b0;
        if (seg_idx != last_r) begin
            adv_idx = seg_idx + AW'(1);
        end else begin
            adv_last = ~loop_r;
        end
    end

    // Next-state and output logic; stop overrides everything.
    always_comb begin
        state_nxt = state;
        idx_nxt   = seg_idx;
        loop_nxt  = loop_r;
        last_nxt  = last_r;
        sel_nxt   = sel;
        delta_nxt = delta;
        gen_nxt   = gen_en;
        done_nxt  = 1'b0;
        cnt_nxt   = cnt;
        ticks_nxt = ticks;
        mem_we    = 1'b0;
        rej_nxt   = wr_en && (state != IDLE);

        unique case (state)
            IDLE: begin
                mem_we = wr_en;
                if (start && !stop) begin
                    loop_nxt  = loop;
                    last_nxt  = last_idx;
                    idx_nxt   = '0;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (rd_seg.dur != '0) begin
                    sel_nxt   = rd_seg.shape;
                    delta_nxt = rd_seg.delta;
                    cnt_nxt   = '0;
                    ticks_nxt = '0;
                    gen_nxt   = 1'b1;
                    state_nxt = RUN;
                end else if (adv_last) begin
                    gen_nxt   = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    idx_nxt   = adv_idx;
                end
            end
            RUN: begin
                if (cnt == delta) begin
                    cnt_nxt   = '0;
                    ticks_nxt = ticks + DUR_BITS'(1);
                    if (ticks == DUR_BITS'(rd_seg.dur - 1'b1)) begin
                        if (adv_last) begin
                            gen_nxt   = 1'b0;
                            done_nxt  = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            idx_nxt   = adv_idx;
                            state_nxt = LOAD;
                        end
                    end
                end else begin
                    cnt_nxt = cnt + bitsDelta'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (stop) begin
            state_nxt = IDLE;
            gen_nxt   = 1'b0;
            done_nxt  = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            seg_idx <= '0;
            loop_r  <= 1'b0;
            last_r  <= '0;
            sel     <= SAWTOOTH;
            delta   <= '0;
            gen_en  <= 1'b0;
            done    <= 1'b0;
            wr_rej  <= 1'b0;
            cnt     <= '0;
            ticks   <= '0;
        end else begin
            state   <= state_nxt;
            seg_idx <= idx_nxt;
            loop_r  <= loop_nxt;
            last_r  <= last_nxt;
            sel     <= sel_nxt;
            delta   <= delta_nxt;
            gen_en  <= gen_nxt;
            done    <= done_nxt;
            wr_rej  <= rej_nxt;
            cnt     <= cnt_nxt;
            ticks   <= ticks_nxt;
        end
    end

endmodule
